// File: rtl/cdb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_pkg
//   Shared types for the common-data-bus producer side.
//   - CDB_DATA  : {valid, tag, value} broadcast word seen by the rob and the
//                 reservation stations.
//   - FU_RESULT : {tag, value} result word produced by every functional unit.
//   Also holds the bus widths and the default arbiter geometry.
// -----------------------------------------------------------------------------
package cdb_arbiter_pkg;

  localparam int XLEN              = 32;
  localparam int ROB_TAG_LEN       = 5;
  localparam int NUM_FU_DEFAULT    = 4;
  localparam int BUF_DEPTH_DEFAULT = 2;

  typedef struct packed {
    logic                   valid;
    logic [ROB_TAG_LEN-1:0] tag;
    logic [XLEN-1:0]        value;
  } CDB_DATA;

  typedef struct packed {
    logic [ROB_TAG_LEN-1:0] tag;
    logic [XLEN-1:0]        value;
  } FU_RESULT;

  // Index width that stays legal (>= 1 bit) for single-entry ranges.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdb_fifo.sv
// -----------------------------------------------------------------------------
// cdb_fifo
//   Per-FU result buffer: FIFO of FU_RESULT words, DEPTH entries (power of 2,
//   >= 2). Occupancy is tracked with a separate count so full/empty never
//   depend on pointer equality.
//
// Ports
//   clock      in   system clock
//   reset      in   asynchronous, active-low
//   flush      in   synchronous clear; overrides push and pop
//   push       in   write push_data (ignored while full, no pass-through)
//   push_data  in   result to store
//   pop        in   drop the head entry (ignored while empty)
//   head       out  oldest stored result
//   empty      out  no entries stored
//   full       out  DEPTH entries stored
// -----------------------------------------------------------------------------
module cdb_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clock,
  input  logic     reset,
  input  logic     flush,
  input  logic     push,
  input  FU_RESULT push_data,
  input  logic     pop,
  output FU_RESULT head,
  output logic     empty,
  output logic     full
);

  localparam int AW = clog2_min1(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  FU_RESULT      mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // A full buffer refuses the write even when it is popped in the same cycle.
  assign do_push = push && !full  && !flush;
  assign do_pop  = pop  && !empty && !flush;

  assign head = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//   Producer side of the common data bus. Buffers completed results from
//   NUM_FU functional units (one cdb_fifo each) and broadcasts at most one per
//   cycle on the registered cdb_data port, picking round-robin among the
//   non-empty buffers starting at rr_ptr.
//
// Configuration macro
//   CDB_BYPASS_EN : when every buffer is empty, the highest round-robin
//                   priority fu_valid result is written straight into
//                   cdb_data (one cycle less latency). Undefined by default:
//                   every result goes through its buffer.
//
// Ports
//   clock      in   system clock
//   reset      in   asynchronous, active-low
//   flush      in   synchronous squash: drop buffered results, kill broadcast
//   fu_valid   in   [NUM_FU]               FU i presents a result
//   fu_tag     in   [NUM_FU][ROB_TAG_LEN]  rob tag of FU i result
//   fu_value   in   [NUM_FU][XLEN]         value of FU i result
//   fu_ready   out  [NUM_FU]               FU i buffer can accept (state only)
//   cdb_data   out  CDB_DATA               registered broadcast
//   pending    out  any result buffered but not yet broadcast
// -----------------------------------------------------------------------------
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_FU    = NUM_FU_DEFAULT,
  parameter int BUF_DEPTH = BUF_DEPTH_DEFAULT
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               flush,
  input  logic [NUM_FU-1:0]                  fu_valid,
  input  logic [NUM_FU-1:0][ROB_TAG_LEN-1:0] fu_tag,
  input  logic [NUM_FU-1:0][XLEN-1:0]        fu_value,
  output logic [NUM_FU-1:0]                  fu_ready,
  output CDB_DATA                            cdb_data,
  output logic                               pending
);

  localparam int PW = clog2_min1(NUM_FU);

  logic [PW-1:0]     rr_ptr;
  FU_RESULT          heads [NUM_FU];
  logic [NUM_FU-1:0] empty;
  logic [NUM_FU-1:0] full;
  logic [NUM_FU-1:0] push;
  logic [NUM_FU-1:0] pop;
  logic              grant_valid;
  logic [PW-1:0]     grant_idx;
  logic              byp_hit;
  logic [PW-1:0]     byp_idx;

  // Returns {found, index} of the first set request at or after ptr, modulo
  // NUM_FU. Scanning from the lowest priority upward lets the last hit win.
  function automatic logic [PW:0] rr_pick(input logic [NUM_FU-1:0] req,
                                          input logic [PW-1:0]     ptr);
    logic [PW:0]   pick;
    logic [PW-1:0] idx;
    pick = '0;
    for (int k = NUM_FU - 1; k >= 0; k--) begin
      idx = PW'((int'(ptr) + k) % NUM_FU);
      if (req[idx]) begin
        pick = {1'b1, idx};
      end
    end
    return pick;
  endfunction

  function automatic logic [PW-1:0] rr_next(input logic [PW-1:0] g);
    return (int'(g) == NUM_FU - 1) ? '0 : g + PW'(1);
  endfunction

  assign {grant_valid, grant_idx} = rr_pick(~empty, rr_ptr);

`ifdef CDB_BYPASS_EN
  logic byp_found;

  // With all buffers empty every FU is ready, so the winning fu_valid is a
  // real transfer that can skip its buffer.
  assign {byp_found, byp_idx} = rr_pick(fu_valid, rr_ptr);
  assign byp_hit = byp_found && !pending && !flush;
`else
  assign byp_hit = 1'b0;
  assign byp_idx = '0;
`endif

  for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
    FU_RESULT in_res;

    assign in_res  = '{tag: fu_tag[i], value: fu_value[i]};
    assign push[i] = fu_valid[i] && !full[i] && !(byp_hit && (byp_idx == PW'(i)));
    assign pop[i]  = grant_valid && (grant_idx == PW'(i));

    cdb_fifo #(
      .DEPTH (BUF_DEPTH)
    ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .flush     (flush),
      .push      (push[i]),
      .push_data (in_res),
      .pop       (pop[i]),
      .head      (heads[i]),
      .empty     (empty[i]),
      .full      (full[i])
    );
  end

  assign fu_ready = ~full;
  assign pending  = |(~empty);

  // Idle cycles drop valid but keep tag/value, so consumers never see the
  // payload change except together with a new valid result.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cdb_data <= '0;
      rr_ptr   <= '0;
    end else if (flush) begin
      cdb_data.valid <= 1'b0;
    end else if (grant_valid) begin
      cdb_data <= '{valid: 1'b1,
                    tag:   heads[grant_idx].tag,
                    value: heads[grant_idx].value};
      rr_ptr   <= rr_next(grant_idx);
    end else if (byp_hit) begin
      cdb_data <= '{valid: 1'b1,
                    tag:   fu_tag[byp_idx],
                    value: fu_value[byp_idx]};
      rr_ptr   <= rr_next(byp_idx);
    end else begin
      cdb_data.valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int NFU = 4;
`ifdef CDB_BYPASS_EN
  localparam int LAT        = 1;
  localparam int BP_ACCEPTS = 3;
  localparam int FLUSH_SEEN = 1;
`else
  localparam int LAT        = 2;
  localparam int BP_ACCEPTS = 2;
  localparam int FLUSH_SEEN = 0;
`endif

  logic                            clock = 1'b0;
  logic                            reset = 1'b0;
  logic                            flush = 1'b0;
  logic [NFU-1:0]                  fu_valid = '0;
  logic [NFU-1:0][ROB_TAG_LEN-1:0] fu_tag = '0;
  logic [NFU-1:0][XLEN-1:0]        fu_value = '0;
  logic [NFU-1:0]                  fu_ready;
  CDB_DATA                         cdb_data;
  logic                            pending;

  int n_checks = 0;
  int n_fail   = 0;

  logic [ROB_TAG_LEN-1:0] log_tag [$];
  logic [XLEN-1:0]        log_val [$];

  int nsent [NFU];
  int limit [NFU];
  int tbase [NFU];
  int first_block [NFU];

  cdb_arbiter #(
    .NUM_FU    (NFU),
    .BUF_DEPTH (2)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .flush    (flush),
    .fu_valid (fu_valid),
    .fu_tag   (fu_tag),
    .fu_value (fu_value),
    .fu_ready (fu_ready),
    .cdb_data (cdb_data),
    .pending  (pending)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (reset && cdb_data.valid) begin
      log_tag.push_back(cdb_data.tag);
      log_val.push_back(cdb_data.value);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_reset();
    @(posedge clock);
    #2;
    reset    = 1'b0;
    flush    = 1'b0;
    fu_valid = '0;
    @(posedge clock);
    #2;
    reset = 1'b1;
    tick();
  endtask

  task automatic clear_log();
    log_tag.delete();
    log_val.delete();
  endtask

  task automatic clear_stream();
    for (int i = 0; i < NFU; i++) begin
      nsent[i]       = 0;
      limit[i]       = 0;
      tbase[i]       = 0;
      first_block[i] = -1;
    end
  endtask

  // Each FU offers limit[i] results with tags tbase[i]+n, holding each one
  // until it transfers. fu_ready depends only on state, so reading it mid-cycle
  // tells whether the coming edge completes the handshake.
  task automatic drive_cycles(input int cycles);
    logic [NFU-1:0] xfer;
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < NFU; i++) begin
        fu_valid[i] = (nsent[i] < limit[i]);
        fu_tag[i]   = ROB_TAG_LEN'(tbase[i] + nsent[i]);
        fu_value[i] = XLEN'(32'h100 + tbase[i] + nsent[i]);
      end
      xfer = fu_valid & fu_ready;
      tick();
      for (int i = 0; i < NFU; i++) begin
        if (xfer[i]) nsent[i]++;
        if (first_block[i] < 0 && nsent[i] < limit[i] && !fu_ready[i])
          first_block[i] = nsent[i];
      end
    end
    fu_valid = '0;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if (cdb_data.valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid got=%0b exp=0", cdb_data.valid);
    end
    n_checks++;
    if (cdb_data.tag !== '0 || cdb_data.value !== '0) begin
      n_fail++; $display("FAIL reset_payload got=%0d/%0d exp=0/0", cdb_data.tag, cdb_data.value);
    end
    n_checks++;
    if (fu_ready !== 4'hF) begin
      n_fail++; $display("FAIL reset_ready got=%b exp=1111", fu_ready);
    end
    n_checks++;
    if (pending !== 1'b0) begin
      n_fail++; $display("FAIL reset_pending got=%0b exp=0", pending);
    end
    @(posedge clock);
    #2;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single();
    logic exp_v, exp_p;
    fu_tag[0]   = 5'd2;
    fu_value[0] = 32'd5;
    fu_valid    = 4'b0001;
    tick();
    fu_valid = '0;
    for (int c = 1; c <= 3; c++) begin
      exp_v = (c == LAT);
      exp_p = (c < LAT);
      n_checks++;
      if (cdb_data.valid !== exp_v) begin
        n_fail++; $display("FAIL single_valid cycle=%0d got=%0b exp=%0b", c, cdb_data.valid, exp_v);
      end
      n_checks++;
      if (pending !== exp_p) begin
        n_fail++; $display("FAIL single_pending cycle=%0d got=%0b exp=%0b", c, pending, exp_p);
      end
      if (exp_v) begin
        n_checks++;
        if (cdb_data.tag !== 5'd2 || cdb_data.value !== 32'd5) begin
          n_fail++; $display("FAIL single_data got=%0d/%0d exp=2/5", cdb_data.tag, cdb_data.value);
        end
      end
      tick();
    end
  endtask

  task automatic test_contention();
    logic exp_v, exp_p;
    do_reset();
    for (int i = 0; i < NFU; i++) begin
      fu_tag[i]   = ROB_TAG_LEN'(i);
      fu_value[i] = XLEN'(10 + i);
    end
    fu_valid = 4'hF;
    tick();
    fu_valid = '0;
    for (int c = 1; c <= 6; c++) begin
      exp_v = (c >= LAT) && (c < LAT + 4);
      exp_p = (c < LAT + 3);
      n_checks++;
      if (cdb_data.valid !== exp_v) begin
        n_fail++; $display("FAIL contention_valid cycle=%0d got=%0b exp=%0b", c, cdb_data.valid, exp_v);
      end
      n_checks++;
      if (pending !== exp_p) begin
        n_fail++; $display("FAIL contention_pending cycle=%0d got=%0b exp=%0b", c, pending, exp_p);
      end
      if (exp_v) begin
        n_checks++;
        if (cdb_data.tag !== ROB_TAG_LEN'(c - LAT) || cdb_data.value !== XLEN'(10 + c - LAT)) begin
          n_fail++; $display("FAIL contention_data cycle=%0d got=%0d/%0d exp=%0d/%0d",
                             c, cdb_data.tag, cdb_data.value, c - LAT, 10 + c - LAT);
        end
      end
      tick();
    end
  endtask

  task automatic test_fairness();
    int exp_tag;
    do_reset();
    clear_stream();
    tbase[1] = 1;
    limit[1] = 1;
    drive_cycles(1);
    idle(4);
    clear_log();
    clear_stream();
    tbase[1] = 8;
    limit[1] = 7;
    tbase[3] = 24;
    limit[3] = 7;
    drive_cycles(20);
    idle(6);
    n_checks++;
    if (nsent[1] !== 7 || nsent[3] !== 7) begin
      n_fail++; $display("FAIL fairness_sent got=%0d/%0d exp=7/7", nsent[1], nsent[3]);
    end
    n_checks++;
    if (log_tag.size() !== 14) begin
      n_fail++; $display("FAIL fairness_count got=%0d exp=14", log_tag.size());
    end
    for (int i = 0; i < log_tag.size() && i < 14; i++) begin
      exp_tag = ((i % 2) == 0 ? 24 : 8) + i / 2;
      n_checks++;
      if (log_tag[i] !== ROB_TAG_LEN'(exp_tag) || log_val[i] !== XLEN'(32'h100 + exp_tag)) begin
        n_fail++; $display("FAIL fairness_order idx=%0d got=%0d/%0h exp=%0d/%0h",
                           i, log_tag[i], log_val[i], exp_tag, 32'h100 + exp_tag);
      end
    end
  endtask

  task automatic test_backpressure();
    int k0, k2;
    do_reset();
    clear_log();
    clear_stream();
    tbase[0] = 0;
    limit[0] = 10;
    tbase[2] = 20;
    limit[2] = 4;
    drive_cycles(14);
    idle(6);
    n_checks++;
    if (nsent[2] !== 4) begin
      n_fail++; $display("FAIL bp_fu2_sent got=%0d exp=4", nsent[2]);
    end
    n_checks++;
    if (first_block[2] !== BP_ACCEPTS) begin
      n_fail++; $display("FAIL bp_ready_drop accepts_before_drop got=%0d exp=%0d", first_block[2], BP_ACCEPTS);
    end
    k0 = 0;
    k2 = 0;
    for (int i = 0; i < log_tag.size(); i++) begin
      n_checks++;
      if (log_tag[i] >= 5'd20) begin
        if (log_tag[i] !== ROB_TAG_LEN'(20 + k2) || log_val[i] !== XLEN'(32'h100 + 20 + k2)) begin
          n_fail++; $display("FAIL bp_fu2_order idx=%0d got=%0d exp=%0d", i, log_tag[i], 20 + k2);
        end
        k2++;
      end else begin
        if (log_tag[i] !== ROB_TAG_LEN'(k0) || log_val[i] !== XLEN'(32'h100 + k0)) begin
          n_fail++; $display("FAIL bp_fu0_order idx=%0d got=%0d exp=%0d", i, log_tag[i], k0);
        end
        k0++;
      end
    end
    n_checks++;
    if (k2 !== 4 || k0 !== nsent[0]) begin
      n_fail++; $display("FAIL bp_lost got=%0d/%0d exp=4/%0d", k2, k0, nsent[0]);
    end
  endtask

  task automatic test_flush();
    do_reset();
    clear_log();
    for (int i = 0; i < NFU; i++) begin
      fu_tag[i]   = ROB_TAG_LEN'(4 + i);
      fu_value[i] = XLEN'(32'h40 + i);
    end
    fu_valid = 4'hF;
    tick();
    fu_tag[0]   = 5'd9;
    fu_value[0] = 32'h99;
    fu_valid    = 4'b0001;
    flush       = 1'b1;
    tick();
    flush    = 1'b0;
    fu_valid = '0;
    n_checks++;
    if (cdb_data.valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_valid got=%0b exp=0", cdb_data.valid);
    end
    n_checks++;
    if (pending !== 1'b0) begin
      n_fail++; $display("FAIL flush_pending got=%0b exp=0", pending);
    end
    n_checks++;
    if (fu_ready !== 4'hF) begin
      n_fail++; $display("FAIL flush_ready got=%b exp=1111", fu_ready);
    end
    idle(5);
    n_checks++;
    if (log_tag.size() !== FLUSH_SEEN) begin
      n_fail++; $display("FAIL flush_leak broadcasts got=%0d exp=%0d", log_tag.size(), FLUSH_SEEN);
    end
    for (int i = 0; i < log_tag.size(); i++) begin
      n_checks++;
      if (log_tag[i] !== 5'd4) begin
        n_fail++; $display("FAIL flush_tag idx=%0d got=%0d exp=4", i, log_tag[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < NFU; i++) begin
      fu_tag[i]   = ROB_TAG_LEN'(12 + i);
      fu_value[i] = XLEN'(32'hC0 + i);
    end
    fu_valid = 4'hF;
    tick();
    fu_valid = '0;
    tick();
    n_checks++;
    if (cdb_data.valid !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_pre_valid got=%0b exp=1", cdb_data.valid);
    end
    #1;
    reset = 1'b0;
    #1;
    n_checks++;
    if (cdb_data.valid !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_async_valid got=%0b exp=0", cdb_data.valid);
    end
    n_checks++;
    if (pending !== 1'b0 || fu_ready !== 4'hF) begin
      n_fail++; $display("FAIL rstmid_state got=%0b/%b exp=0/1111", pending, fu_ready);
    end
    #1;
    reset = 1'b1;
    tick();
    clear_log();
    fu_tag[0]   = 5'd1;
    fu_value[0] = 32'h11;
    fu_tag[3]   = 5'd2;
    fu_value[3] = 32'h22;
    fu_valid    = 4'b1001;
    tick();
    fu_valid = '0;
    idle(4);
    n_checks++;
    if (log_tag.size() !== 2) begin
      n_fail++; $display("FAIL rstmid_count got=%0d exp=2", log_tag.size());
    end else begin
      n_checks++;
      if (log_tag[0] !== 5'd1 || log_tag[1] !== 5'd2) begin
        n_fail++; $display("FAIL rstmid_first_grant got=%0d,%0d exp=1,2", log_tag[0], log_tag[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
